// File: rtl/nn_pkg.sv
// Shared constants, state encoding and sample-word helpers for the
// FeedForwardNN on-chip sample driver.
package nn_pkg;

    localparam int DATA_W     = 9;
    localparam int NUM_INPUTS = 4;
    localparam int LABEL_W    = 2;
    localparam int WORD_W     = NUM_INPUTS * DATA_W + LABEL_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    typedef logic [WORD_W-1:0] sample_word_t;

    function automatic sample_word_t pack_sample(
        input logic [LABEL_W-1:0] lbl,
        input logic [DATA_W-1:0]  x3,
        input logic [DATA_W-1:0]  x2,
        input logic [DATA_W-1:0]  x1,
        input logic [DATA_W-1:0]  x0
    );
        return {lbl, x3, x2, x1, x0};
    endfunction

    function automatic logic [LABEL_W-1:0] unpack_label(
        input sample_word_t w
    );
        return w[WORD_W-1 -: LABEL_W];
    endfunction

    function automatic logic [DATA_W-1:0] unpack_x(
        input sample_word_t w,
        input int           i
    );
        return w[i*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/nn_sample_mem.sv
// Sample memory: synchronous write, two combinational read ports
// (current label and next feature vector).
module nn_sample_mem
    import nn_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = WORD_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr0_i,
    output logic [WIDTH-1:0] rdata0_o,
    input  logic [AW-1:0]    raddr1_i,
    output logic [WIDTH-1:0] rdata1_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/nn_sample_driver.sv
// Presents stored feature vectors to the NN, waits its latency, scores
// {y1,y0} against the stored label and reports the correct count.
module nn_sample_driver #(
    parameter  int NUM_SAMPLES = 16,
    parameter  int DATA_W      = nn_pkg::DATA_W,
    parameter  int NN_LATENCY  = 3,
    localparam int AW          = $clog2(NUM_SAMPLES),
    localparam int CW          = $clog2(NUM_SAMPLES + 1),
    localparam int LW          = 4 * DATA_W + 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     load_en,
    input  logic [AW-1:0]            load_addr,
    input  logic [LW-1:0]            load_data,
    input  logic                     start,
    output logic signed [DATA_W-1:0] x0,
    output logic signed [DATA_W-1:0] x1,
    output logic signed [DATA_W-1:0] x2,
    output logic signed [DATA_W-1:0] x3,
    input  logic                     y0,
    input  logic                     y1,
    output logic                     busy,
    output logic                     done,
    output logic [AW-1:0]            sample_idx,
    output logic [CW-1:0]            correct_count
);
    import nn_pkg::*;

    localparam int XW = NUM_INPUTS * DATA_W;
    localparam int WW = (NN_LATENCY > 1) ? $clog2(NN_LATENCY) : 1;
    localparam logic [WW-1:0] LAT_LAST = WW'(NN_LATENCY - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_SAMPLES - 1);

    logic [1:0]    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NUM_INPUTS-1:0][DATA_W-1:0] x_q, x_d;

    logic          mem_we;
    logic [AW-1:0] nxt_addr;
    logic [LW-1:0] cur_word;
    logic [LW-1:0] nxt_word;
    logic          capture;
    logic          hit;

    assign mem_we = load_en && (state_q == ST_IDLE);

    // In IDLE the next vector is sample 0; in RUN it is the one after idx.
    assign nxt_addr = (state_q == ST_RUN) ? idx_q + AW'(1) : '0;

    nn_sample_mem #(
        .DEPTH (NUM_SAMPLES),
        .WIDTH (LW)
    ) u_mem (
        .clk_i    (CLK),
        .we_i     (mem_we),
        .waddr_i  (load_addr),
        .wdata_i  (load_data),
        .raddr0_i (idx_q),
        .rdata0_o (cur_word),
        .raddr1_i (nxt_addr),
        .rdata1_o (nxt_word)
    );

    assign capture = (state_q == ST_RUN) && (wait_q == LAT_LAST);
    assign hit     = ({y1, y0} == cur_word[LW-1 -: LABEL_W]);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        unique case (1'b1)
            (state_q == ST_IDLE): begin
                if (start) begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    x_d     = nxt_word[XW-1:0];
                end
            end
            (state_q == ST_RUN): begin
                wait_d = wait_q + WW'(1);
                if (capture) begin
                    if (hit) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (idx_q != IDX_LAST) begin
                        idx_d  = idx_q + AW'(1);
                        x_d    = nxt_word[XW-1:0];
                        wait_d = '0;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            (state_q == ST_FINISH): begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
        end
    end

    assign x0            = x_q[0];
    assign x1            = x_q[1];
    assign x2            = x_q[2];
    assign x3            = x_q[3];
    assign busy          = (state_q == ST_RUN);
    assign done          = (state_q == ST_FINISH);
    assign sample_idx    = idx_q;
    assign correct_count = cnt_q;

endmodule

// File: tb/tb_nn_sample_driver.sv
// Directed + randomized bench for nn_sample_driver: a 2-sample/latency-3
// instance and a 16-sample/latency-1 instance against a cycle model.
module tb_nn_sample_driver;
    import nn_pkg::*;

    localparam int AN = 2;
    localparam int AL = 3;
    localparam int BN = 16;
    localparam int BL = 1;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic              la_en = 0, la_start = 0;
    logic [0:0]        la_addr = '0;
    logic [37:0]       la_data = '0;
    logic signed [8:0] xa0, xa1, xa2, xa3;
    logic              ya0, ya1, busy_a, done_a;
    logic [0:0]        idx_a;
    logic [1:0]        cnt_a;

    logic              lb_en = 0, lb_start = 0;
    logic [3:0]        lb_addr = '0;
    logic [37:0]       lb_data = '0;
    logic signed [8:0] xb0, xb1, xb2, xb3;
    logic              yb0, yb1, busy_b, done_b;
    logic [3:0]        idx_b;
    logic [4:0]        cnt_b;

    nn_sample_driver #(
        .NUM_SAMPLES (AN), .DATA_W (9), .NN_LATENCY (AL)
    ) u_a (
        .CLK (CLK), .RST_N (RST_N),
        .load_en (la_en), .load_addr (la_addr), .load_data (la_data),
        .start (la_start),
        .x0 (xa0), .x1 (xa1), .x2 (xa2), .x3 (xa3),
        .y0 (ya0), .y1 (ya1),
        .busy (busy_a), .done (done_a),
        .sample_idx (idx_a), .correct_count (cnt_a)
    );

    nn_sample_driver #(
        .NUM_SAMPLES (BN), .DATA_W (9), .NN_LATENCY (BL)
    ) u_b (
        .CLK (CLK), .RST_N (RST_N),
        .load_en (lb_en), .load_addr (lb_addr), .load_data (lb_data),
        .start (lb_start),
        .x0 (xb0), .x1 (xb1), .x2 (xb2), .x3 (xb3),
        .y0 (yb0), .y1 (yb1),
        .busy (busy_b), .done (done_b),
        .sample_idx (idx_b), .correct_count (cnt_b)
    );

    // NN stand-ins: classify by the presented x0 value
    bit         bad_a = 0;
    int         ax [AN][4] = '{'{159, 205, 81, 76}, '{0, 0, 0, 0}};
    logic [1:0] lbl_b [BN];
    bit         wrong_b [BN];
    int         bx [BN][4];

    assign {ya1, ya0} = bad_a ? 2'b11 : ((xa0 == 9'sd159) ? 2'b01 : 2'b10);
    assign {yb1, yb0} = lbl_b[xb0[3:0]] ^ {1'b0, wrong_b[xb0[3:0]]};

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_a(input bit bad, input bit disturb);
        int cur;
        bad_a = bad;
        la_start = 1;
        step();
        la_start = 0;
        for (int k = 0; k <= AN * AL; k++) begin
            cur = (k < AN * AL) ? k / AL : AN - 1;
            chk("a_busy", int'(busy_a), int'(k < AN * AL));
            chk("a_done", int'(done_a), int'(k == AN * AL));
            chk("a_idx", int'(idx_a), cur);
            chk("a_x0", int'(xa0), ax[cur][0]);
            chk("a_cnt", int'(cnt_a), bad ? 0 : k / AL);
            if (k == 0) begin
                chk("a_x1", int'(xa1), ax[0][1]);
                chk("a_x2", int'(xa2), ax[0][2]);
                chk("a_x3", int'(xa3), ax[0][3]);
            end
            la_start = disturb && (k == 1 || k == AN * AL);
            la_en    = disturb && (k == 2);
            la_addr  = '0;
            la_data  = '0;
            step();
        end
        la_start = 0;
        la_en    = 0;
        chk("a_post_busy", int'(busy_a), 0);
        chk("a_post_done", int'(done_a), 0);
        chk("a_post_cnt", int'(cnt_a), bad ? 0 : AN);
    endtask

    initial begin
        int good;
        int nwrong;
        int j;
        int cur;

        step();
        step();
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_x0", int'(xa0), 0);
        RST_N = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_busy", int'(busy_a), 0);
            chk("idle_done", int'(done_a), 0);
            chk("idle_idx", int'(idx_a), 0);
            chk("idle_cnt", int'(cnt_a), 0);
            chk("idle_x", int'({xa3, xa2, xa1, xa0}), 0);
            chk("idle_b", int'({busy_b, done_b, cnt_b, idx_b}), 0);
        end

        la_en   = 1;
        la_addr = 1'b0;
        la_data = pack_sample(2'b01, 9'd76, 9'd81, 9'd205, 9'd159);
        step();
        la_addr = 1'b1;
        la_data = pack_sample(2'b10, 9'd0, 9'd0, 9'd0, 9'd0);
        step();
        la_en = 0;

        run_a(0, 0);
        run_a(1, 0);
        run_a(0, 1);
        run_a(0, 0);

        bad_a = 0;
        la_start = 1;
        step();
        la_start = 0;
        repeat (4) step();
        chk("mid_idx", int'(idx_a), 1);
        chk("mid_cnt", int'(cnt_a), 1);
        RST_N = 0;
        #1;
        chk("arst_busy", int'(busy_a), 0);
        chk("arst_x0", int'(xa0), 0);
        chk("arst_idx", int'(idx_a), 0);
        chk("arst_cnt", int'(cnt_a), 0);
        step();
        RST_N = 1;
        step();
        run_a(0, 0);

        for (int i = 0; i < BN; i++) begin
            bx[i][0] = i;
            for (int c = 1; c < 4; c++) bx[i][c] = $urandom_range(0, 511);
            lbl_b[i]   = 2'($urandom_range(0, 3));
            wrong_b[i] = 0;
            lb_en   = 1;
            lb_addr = 4'(i);
            lb_data = pack_sample(lbl_b[i], 9'(bx[i][3]), 9'(bx[i][2]),
                                  9'(bx[i][1]), 9'(bx[i][0]));
            step();
        end
        lb_en = 0;
        nwrong = 0;
        while (nwrong < 5) begin
            j = $urandom_range(0, BN - 1);
            if (!wrong_b[j]) begin
                wrong_b[j] = 1;
                nwrong++;
            end
        end

        lb_start = 1;
        step();
        lb_start = 0;
        good = 0;
        for (int k = 0; k <= BN * BL; k++) begin
            cur = (k < BN) ? k : BN - 1;
            chk("b_busy", int'(busy_b), int'(k < BN));
            chk("b_done", int'(done_b), int'(k == BN));
            chk("b_idx", int'(idx_b), cur);
            chk("b_x0", int'(xb0), bx[cur][0]);
            chk("b_cnt", int'(cnt_b), good);
            if (k == 3) begin
                chk("b_x1", int'($unsigned(xb1)), bx[3][1]);
                chk("b_x3", int'($unsigned(xb3)), bx[3][3]);
            end
            if (k < BN && !wrong_b[k]) good++;
            step();
        end
        chk("b_final_cnt", int'(cnt_b), 11);
        chk("b_final_busy", int'(busy_b), 0);
        chk("b_hold_x0", int'(xb0), BN - 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
